// File: rtl/pixel_readout_pkg.sv
// rtl/pixel_readout_pkg.sv - shared constants and types for the pixel readout block
package pixel_readout_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_NCH = 4;
    localparam int DEF_FCW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } rd_state_t;

    typedef logic [DEF_DW-1:0] pix_t;
    typedef pix_t pix_bus_t [DEF_NCH];

endpackage

// File: rtl/pixel_readout_ramp_counter.sv
// rtl/pixel_readout_ramp_counter.sv - saturating ADC reference ramp counter
module ramp_counter
    import pixel_readout_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          convert,
    output logic [DW-1:0] cnt,
    output logic          sat
);

    localparam logic [DW-1:0] RAMP_MAX = {DW{1'b1}};

    // Count up while converting, park at full scale, restart from zero otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!convert) begin
            cnt <= '0;
        end else if (cnt != RAMP_MAX) begin
            cnt <= cnt + DW'(1);
        end
    end

    // Saturation is simply the counter sitting at full scale
    assign sat = (cnt == RAMP_MAX);

endmodule

// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - host end of the pixel-array data bus: ramp drive, capture, stream out
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int NCH = DEF_NCH,
    parameter int FCW = DEF_FCW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              convert,
    input  logic              read,
    input  logic [NCH*DW-1:0] pix_in,
    output logic [DW-1:0]     bus_out,
    output logic              bus_oe,
    output logic              ramp_en,
    output logic              ramp_sat,
    output logic [DW-1:0]     out_data,
    output logic [1:0]        out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FCW-1:0]    frame_cnt,
    output logic              overrun,
    output logic              proto_err
);

    localparam logic [1:0] LAST_CH = 2'(NCH - 1);

    rd_state_t     state;
    logic [DW-1:0] cap_buf [NCH];
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    // Set when read is seen high during a drain; blocks capture until read drops
    logic          rd_block;

    assign idx_nxt = idx + 2'd1;

    ramp_counter #(.DW(DW)) u_ramp (
        .clk     (clk),
        .reset   (reset),
        .convert (convert),
        .cnt     (bus_out),
        .sat     (ramp_sat)
    );

    // Buses are released in the very cycle read rises; the analog ramp gate follows convert
    assign bus_oe  = ~read;
    assign ramp_en = convert;

    // Capture/drain FSM with registered stream outputs and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            rd_block  <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            proto_err <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                cap_buf[c] <= '0;
            end
        end else begin
            if (convert && read) begin
                proto_err <= 1'b1;
            end
            if (!read) begin
                rd_block <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (read && !rd_block) begin
                        for (int c = 0; c < NCH; c++) begin
                            cap_buf[c] <= pix_in[c*DW +: DW];
                        end
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (read) begin
                        // Keep resampling so the value present on the last read cycle wins
                        for (int c = 0; c < NCH; c++) begin
                            cap_buf[c] <= pix_in[c*DW +: DW];
                        end
                    end else begin
                        frame_cnt <= frame_cnt + FCW'(1);
                        idx       <= '0;
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        out_data  <= cap_buf[0];
                        out_ch    <= '0;
                        out_last  <= (LAST_CH == 2'd0);
                    end
                end
                DRAIN: begin
                    if (read) begin
                        // Buffer is busy: the incoming frame is dropped
                        overrun  <= 1'b1;
                        rd_block <= 1'b1;
                    end
                    if (out_ready) begin
                        if (idx == LAST_CH) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_ch    <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx_nxt;
                            out_data <= cap_buf[idx_nxt];
                            out_ch   <= idx_nxt;
                            out_last <= (idx_nxt == LAST_CH);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout.sv
// tb/tb_pixel_readout.sv - randomized scoreboard bench for pixel_readout
module tb_pixel_readout;
    import pixel_readout_pkg::*;

    localparam int DW  = DEF_DW;
    localparam int NCH = DEF_NCH;
    localparam int FCW = DEF_FCW;

    logic              clk = 1'b0;
    logic              reset;
    logic              convert;
    logic              read;
    logic [NCH*DW-1:0] pix_in;
    logic [DW-1:0]     bus_out;
    logic              bus_oe;
    logic              ramp_en;
    logic              ramp_sat;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [FCW-1:0]    frame_cnt;
    logic              overrun;
    logic              proto_err;

    pixel_readout dut (
        .clk       (clk),
        .reset     (reset),
        .convert   (convert),
        .read      (read),
        .pix_in    (pix_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .ramp_en   (ramp_en),
        .ramp_sat  (ramp_sat),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .overrun   (overrun),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        pix_t       data;
        logic [1:0] ch;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    model_frames = 0;
    bit    model_ovr = 1'b0;
    bit    model_proto = 1'b0;
    bit    rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Monitor: compare every accepted beat against the scoreboard, and check stall stability
    beat_t held;
    bit    held_v = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else if (out_valid) begin
            if (held_v) begin
                chk("stall_data", 32'(out_data), 32'(held.data));
                chk("stall_ch", 32'(out_ch), 32'(held.ch));
                chk("stall_last", 32'(out_last), 32'(held.last));
            end
            if (out_ready) begin
                held_v = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_ch", 32'(out_ch), 32'(e.ch));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
            end else begin
                held_v = 1'b1;
                held.data = out_data;
                held.ch = out_ch;
                held.last = out_last;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // One read window of len cycles; the last sample presented is the frame's content
    task automatic do_frame(input int len, input bit conv, input bit fixed,
                            input logic [NCH*DW-1:0] word);
        pix_bus_t exp_v;
        for (int k = 0; k < len; k++) begin
            read = 1'b1;
            convert = conv && (k == 0);
            pix_in = fixed ? word : {$urandom, $urandom};
            for (int c = 0; c < NCH; c++) exp_v[c] = pix_in[c*DW +: DW];
            if (conv && k == 0) begin
                #1;
                chk("proto_bus_oe", 32'(bus_oe), 32'd0);
                step();
                model_proto = 1'b1;
                chk("proto_err", 32'(proto_err), 32'd1);
                chk("proto_cnt", 32'(bus_out), 32'd1);
            end else begin
                step();
            end
        end
        read = 1'b0;
        convert = 1'b0;
        pix_in = {$urandom, $urandom};
        step();
        model_frames++;
        for (int c = 0; c < NCH; c++) begin
            beat_t b;
            b.data = exp_v[c];
            b.ch = 2'(c);
            b.last = (c == NCH - 1);
            sb.push_back(b);
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(model_frames));
    endtask

    task automatic wait_drain();
        int budget = 300;
        while (sb.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        chk("valid_after_drain", 32'(out_valid), 32'd0);
        chk("overrun", 32'(overrun), 32'(model_ovr));
        chk("proto_flag", 32'(proto_err), 32'(model_proto));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        convert = 1'b0;
        read = 1'b0;
        pix_in = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        chk("rst_bus_oe", 32'(bus_oe), 32'd1);
        chk("rst_ramp", {29'd0, ramp_en, ramp_sat, out_valid}, 32'd0);
        chk("rst_stream", {21'd0, out_data, out_ch, out_last}, 32'd0);
        chk("rst_flags", {14'd0, frame_cnt, overrun, proto_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Ramp: counts up, saturates at full scale, clears when convert drops
        convert = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            step();
            chk("ramp_cnt", 32'(bus_out), (i < 255) ? 32'(i) : 32'd255);
            chk("ramp_sat", 32'(ramp_sat), (i >= 255) ? 32'd1 : 32'd0);
        end
        chk("ramp_en", 32'(ramp_en), 32'd1);
        convert = 1'b0;
        step();
        chk("ramp_clear", 32'(bus_out), 32'd0);
        chk("ramp_sat_clear", 32'(ramp_sat), 32'd0);

        // Directed capture of a known pattern
        out_ready = 1'b1;
        do_frame(3, 1'b0, 1'b1, 32'h11223344);
        wait_drain();

        // Backpressure: five stalled cycles, then toggling ready
        out_ready = 1'b0;
        do_frame(2, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 12; i++) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        wait_drain();

        // Randomized frames with random ready
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            do_frame($urandom_range(1, 4), 1'b0, 1'b0, '0);
            wait_drain();
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
        end

        // Overrun: read pulse while ch1 is pending leaves the old frame intact
        rand_ready = 1'b0;
        out_ready = 1'b0;
        do_frame(2, 1'b0, 1'b1, 32'hA1B2C3D4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        read = 1'b1;
        pix_in = 32'h55667788;
        step();
        read = 1'b0;
        model_ovr = 1'b1;
        step();
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_fcnt", 32'(frame_cnt), 32'(model_frames));
        out_ready = 1'b1;
        wait_drain();

        // Read held high across the end of a drain must not start a capture
        out_ready = 1'b0;
        do_frame(1, 1'b0, 1'b0, '0);
        read = 1'b1;
        step();
        step();
        rand_ready = 1'b1;
        wait_drain();
        for (int i = 0; i < 3; i++) step();
        chk("held_read_valid", 32'(out_valid), 32'd0);
        chk("held_read_fcnt", 32'(frame_cnt), 32'(model_frames));
        read = 1'b0;
        step();

        // Protocol error: convert and read together
        do_frame(2, 1'b1, 1'b0, '0);
        wait_drain();

        // Reset in the middle of a drain
        rand_ready = 1'b0;
        out_ready = 1'b0;
        do_frame(2, 1'b0, 1'b0, '0);
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_flags", {14'd0, frame_cnt, overrun, proto_err}, 32'd0);
        sb.delete();
        model_frames = 0;
        model_ovr = 1'b0;
        model_proto = 1'b0;
        step();
        reset = 1'b0;
        rand_ready = 1'b1;
        do_frame(3, 1'b0, 1'b0, '0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
